// File: rtl/fetch_queue_pkg.sv
// Shared pipeline constants and the fetch-queue entry type.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: producer side, consumer side, flush and occupancy.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import fetch_queue_pkg::*;

  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [ILEN-1:0]   in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [ILEN-1:0]   out_instr;
  logic [CountW-1:0] count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular first-word fall-through instruction queue between fetch and decode.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  fetch_queue_if.slave q
);
  import fetch_queue_pkg::*;

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  logic            empty, full;
  fetch_entry_t    in_entry, head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  assign q.in_ready  = !full;
  assign q.out_valid = !empty;
  assign q.count     = count_q;

  assign in_entry.pc    = q.in_pc;
  assign in_entry.instr = q.in_instr;

  // Empty queue presents a harmless NOP rather than stale storage.
  always_comb begin
    head = mem_q[rd_ptr_q];
    if (empty) begin
      head.pc    = '0;
      head.instr = NOP_INSTR;
    end
  end

  assign q.out_pc    = head.pc;
  assign q.out_instr = head.instr;

  always_comb begin
    push     = q.in_valid && !full && !q.flush;
    pop      = q.out_ready && !empty && !q.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately unreset; it is unobservable while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model checked every cycle.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   model_on = 1'b0;

  fetch_entry_t model_q[$];

  fetch_queue_if #(.DEPTH(DEPTH)) q ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .q    (q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A00_0003;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model-driven compare on every falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("m_in_ready", 64'(q.in_ready), 64'(model_q.size() < DEPTH));
      check("m_out_valid", 64'(q.out_valid), 64'(model_q.size() != 0));
      check("m_count", 64'(q.count), 64'(model_q.size()));
      check("m_out_pc", q.out_pc, (model_q.size() != 0) ? model_q[0].pc : 64'h0);
      check("m_out_instr", 64'(q.out_instr),
            64'((model_q.size() != 0) ? model_q[0].instr : NOP_INSTR));
    end
  end

  task automatic drive(input bit v, input logic [63:0] pc, input bit rdy, input bit fl);
    q.in_valid  = v;
    q.in_pc     = pc;
    q.in_instr  = instr_of(pc);
    q.out_ready = rdy;
    q.flush     = fl;
  endtask

  // One clock: drive, update the model at the edge, return at the next falling edge.
  task automatic cycle(input bit v, input logic [63:0] pc, input bit rdy, input bit fl);
    bit push;
    bit pop;
    fetch_entry_t e;
    drive(v, pc, rdy, fl);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      push = v && (model_q.size() < DEPTH);
      pop  = rdy && (model_q.size() != 0);
      if (pop) void'(model_q.pop_front());
      if (push) begin
        e.pc    = pc;
        e.instr = instr_of(pc);
        model_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    #12;
    check("rst_in_ready", 64'(q.in_ready), 64'd1);
    check("rst_out_valid", 64'(q.out_valid), 64'd0);
    check("rst_count", 64'(q.count), 64'd0);
    check("rst_out_pc", q.out_pc, 64'h0);
    check("rst_out_instr", 64'(q.out_instr), 64'h13);
    @(negedge clk);
    reset = 1'b0;
    model_on = 1'b1;

    // Three pushes held, then drained in order.
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'(4 * i), 1'b0, 1'b0);
    check("fill3_count", 64'(q.count), 64'd3);
    check("fill3_pc", q.out_pc, 64'h0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    check("pop1_pc", q.out_pc, 64'h4);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    check("pop2_pc", q.out_pc, 64'h8);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    check("drain_valid", 64'(q.out_valid), 64'd0);
    check("drain_instr", 64'(q.out_instr), 64'h13);

    // Full queue ignores a fifth push; one pop reopens it.
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'h10 + 64'(4 * i), 1'b0, 1'b0);
    check("full_in_ready", 64'(q.in_ready), 64'd0);
    check("full_count", 64'(q.count), 64'd4);
    cycle(1'b1, 64'h20, 1'b0, 1'b0);
    check("full_ignore_count", 64'(q.count), 64'd4);
    check("full_ignore_pc", q.out_pc, 64'h10);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    check("reopen_in_ready", 64'(q.in_ready), 64'd1);
    check("reopen_count", 64'(q.count), 64'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0);
    check("full_drained", 64'(q.count), 64'd0);

    // Streaming at occupancy 2; pointers wrap several times.
    cycle(1'b1, 64'h40, 1'b0, 1'b0);
    cycle(1'b1, 64'h44, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 64'h48 + 64'(4 * i), 1'b1, 1'b0);
      check("stream_count", 64'(q.count), 64'd2);
      check("stream_pc", q.out_pc, 64'h44 + 64'(4 * i));
    end

    // Flush beats simultaneous push and pop.
    cycle(1'b1, 64'h70, 1'b0, 1'b0);
    check("pre_flush_count", 64'(q.count), 64'd3);
    cycle(1'b1, 64'h200, 1'b1, 1'b1);
    check("flush_count", 64'(q.count), 64'd0);
    check("flush_valid", 64'(q.out_valid), 64'd0);
    check("flush_in_ready", 64'(q.in_ready), 64'd1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    check("flush_idle_valid", 64'(q.out_valid), 64'd0);
    cycle(1'b1, 64'h300, 1'b0, 1'b0);
    check("post_flush_pc", q.out_pc, 64'h300);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    cycle(1'b1, 64'h500, 1'b0, 1'b0);
    cycle(1'b1, 64'h504, 1'b0, 1'b0);
    check("pre_reset_count", 64'(q.count), 64'd2);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    model_q.delete();
    #1;
    check("async_rst_valid", 64'(q.out_valid), 64'd0);
    check("async_rst_count", 64'(q.count), 64'd0);
    check("async_rst_pc", q.out_pc, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 64'h600, 1'b0, 1'b0);
    check("post_rst_pc", q.out_pc, 64'h600);
    check("post_rst_instr", 64'(q.out_instr), 64'(instr_of(64'h600)));
    cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Empty queue: no combinational bypass from input to output.
    drive(1'b1, 64'h100, 1'b1, 1'b0);
    #1;
    check("no_bypass_valid", 64'(q.out_valid), 64'd0);
    check("no_bypass_pc", q.out_pc, 64'h0);
    cycle(1'b1, 64'h100, 1'b1, 1'b0);
    check("bypass_next_valid", 64'(q.out_valid), 64'd1);
    check("bypass_next_pc", q.out_pc, 64'h100);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    check("final_empty", 64'(q.count), 64'd0);

    model_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
